// File: rtl/axis_pkg.sv
// ---------------------------------------------------------------------------
// axis_pkg
//   Shared definitions for the AXI-Stream width converters.
//   - Default single-beat data / user / counter widths.
//   - keep_width(): byte-enable width for a given data width.
//   - PACK_ORDER: where the first beat of a pair lands in the double word.
// ---------------------------------------------------------------------------
package axis_pkg;

    localparam int AXIS_DATA_WIDTH_DEF  = 512;
    localparam int AXIS_TUSER_WIDTH_DEF = 256;
    localparam int COUNT_WIDTH_DEF      = 32;

    // First beat of a pair goes in the low half; the egress FIFO relies on it.
    typedef enum logic {
        PACK_LO_FIRST = 1'b0,
        PACK_HI_FIRST = 1'b1
    } pack_order_e;

    localparam pack_order_e PACK_ORDER = PACK_LO_FIRST;

    function automatic int keep_width(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/axis_pack_double.sv
// ---------------------------------------------------------------------------
// axis_pack_double
//   Width up-converter feeding the half-rate egress FIFO. Consecutive
//   single-width beats are paired into one double-width word, first beat in
//   the low half. An odd-length packet is closed with a zero-keep high half.
//   A running count of emitted packets is kept.
//
// Ports
//   aclk, reset        clock, synchronous active-high reset
//   s_axis_*           single-width input stream (tdata/tkeep/tuser/tvalid/
//                      tlast/tready)
//   m_axis_*           double-width output stream {hi, lo}, driven from flops
//   pkt_count          number of tlast handshakes on the output, wraps
// ---------------------------------------------------------------------------
module axis_pack_double
    import axis_pkg::*;
#(
    parameter int AXIS_DATA_WIDTH  = AXIS_DATA_WIDTH_DEF,
    parameter int AXIS_TUSER_WIDTH = AXIS_TUSER_WIDTH_DEF,
    parameter int COUNT_WIDTH      = COUNT_WIDTH_DEF
) (
    input  logic                            aclk,
    input  logic                            reset,

    input  logic [AXIS_DATA_WIDTH-1:0]      s_axis_tdata,
    input  logic [AXIS_DATA_WIDTH/8-1:0]    s_axis_tkeep,
    input  logic [AXIS_TUSER_WIDTH-1:0]     s_axis_tuser,
    input  logic                            s_axis_tvalid,
    input  logic                            s_axis_tlast,
    output logic                            s_axis_tready,

    output logic [2*AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [2*AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
    output logic [2*AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                            m_axis_tvalid,
    output logic                            m_axis_tlast,
    input  logic                            m_axis_tready,

    output logic [COUNT_WIDTH-1:0]          pkt_count
);

    localparam int KEEP_W = keep_width(AXIS_DATA_WIDTH);

    // Held first half of a pair.
    logic [AXIS_DATA_WIDTH-1:0]  lo_data;
    logic [KEEP_W-1:0]           lo_keep;
    logic [AXIS_TUSER_WIDTH-1:0] lo_user;
    logic                        have_lo;

    logic s_acc;
    logic m_hs;
    logic load_out;

    // Candidate word halves for the out register.
    logic [AXIS_DATA_WIDTH-1:0]  lo_d;
    logic [AXIS_DATA_WIDTH-1:0]  hi_d;
    logic [KEEP_W-1:0]           lo_k;
    logic [KEEP_W-1:0]           hi_k;
    logic [AXIS_TUSER_WIDTH-1:0] lo_u;
    logic [AXIS_TUSER_WIDTH-1:0] hi_u;

    // Ready only depends on the out register, never on the input beat itself,
    // so upstream may legally wait for ready before raising valid.
    assign s_axis_tready = !reset && (!m_axis_tvalid || m_axis_tready);

    assign s_acc    = s_axis_tvalid && s_axis_tready;
    assign m_hs     = m_axis_tvalid && m_axis_tready;
    // A word is complete when the second beat arrives or a packet ends on
    // an unpaired first beat.
    assign load_out = s_acc && (have_lo || s_axis_tlast);

    always_comb begin
        lo_d = s_axis_tdata;
        lo_k = s_axis_tkeep;
        lo_u = s_axis_tuser;
        hi_d = '0;
        hi_k = '0;
        hi_u = '0;
        if (have_lo) begin
            lo_d = lo_data;
            lo_k = lo_keep;
            lo_u = lo_user;
            hi_d = s_axis_tdata;
            hi_k = s_axis_tkeep;
            hi_u = s_axis_tuser;
        end
    end

    // ---- stage: lo half capture ----
    always_ff @(posedge aclk) begin
        if (s_acc && !have_lo && !s_axis_tlast) begin
            lo_data <= s_axis_tdata;
            lo_keep <= s_axis_tkeep;
            lo_user <= s_axis_tuser;
        end
    end

    // ---- stage: out register and packet counter ----
    always_ff @(posedge aclk) begin
        if (reset) begin
            have_lo       <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tuser  <= '0;
            pkt_count     <= '0;
        end else begin
            if (m_hs && m_axis_tlast) begin
                pkt_count <= pkt_count + COUNT_WIDTH'(1);
            end

            // A new word may replace the one leaving in the same cycle.
            if (load_out) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tlast  <= s_axis_tlast;
                if (PACK_ORDER == PACK_LO_FIRST) begin
                    m_axis_tdata <= {hi_d, lo_d};
                    m_axis_tkeep <= {hi_k, lo_k};
                    m_axis_tuser <= {hi_u, lo_u};
                end else begin
                    m_axis_tdata <= {lo_d, hi_d};
                    m_axis_tkeep <= {lo_k, hi_k};
                    m_axis_tuser <= {lo_u, hi_u};
                end
            end else if (m_hs) begin
                m_axis_tvalid <= 1'b0;
            end

            if (s_acc) begin
                if (have_lo) begin
                    have_lo <= 1'b0;
                end else if (!s_axis_tlast) begin
                    have_lo <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_axis_pack_double.sv
// ---------------------------------------------------------------------------
// tb_axis_pack_double
//   Scoreboard bench for axis_pack_double. The driver feeds packets and, on
//   every accepted beat, updates a packet-level model that groups beats in
//   pairs and queues the expected double word. A separate monitor compares
//   each presented word against the queue head.
// ---------------------------------------------------------------------------
module tb_axis_pack_double;

    localparam int DW = 64;
    localparam int UW = 16;
    localparam int CW = 8;
    localparam int KW = DW / 8;

    logic              aclk = 1'b0;
    logic              reset = 1'b1;
    logic [DW-1:0]     s_axis_tdata = '0;
    logic [KW-1:0]     s_axis_tkeep = '0;
    logic [UW-1:0]     s_axis_tuser = '0;
    logic              s_axis_tvalid = 1'b0;
    logic              s_axis_tlast = 1'b0;
    logic              s_axis_tready;
    logic [2*DW-1:0]   m_axis_tdata;
    logic [2*KW-1:0]   m_axis_tkeep;
    logic [2*UW-1:0]   m_axis_tuser;
    logic              m_axis_tvalid;
    logic              m_axis_tlast;
    logic              m_axis_tready = 1'b1;
    logic [CW-1:0]     pkt_count;

    axis_pack_double #(
        .AXIS_DATA_WIDTH  (DW),
        .AXIS_TUSER_WIDTH (UW),
        .COUNT_WIDTH      (CW)
    ) dut (
        .aclk          (aclk),
        .reset         (reset),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .pkt_count     (pkt_count)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [2*DW-1:0] data;
        logic [2*KW-1:0] keep;
        logic [2*UW-1:0] user;
        logic            last;
        int              cyc;
    } word_t;

    typedef struct {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic [UW-1:0] u;
    } beat_t;

    word_t exp_q[$];
    beat_t cur[$];
    word_t mon_w;

    int checks = 0;
    int errors = 0;
    int model_count = 0;
    int cyc = 0;
    int mready_mode = 0;   // 0: always ready, 1: random, 2: held low
    logic prev_v = 1'b0;
    logic prev_hs = 1'b0;

    always @(posedge aclk) cyc <= cyc + 1;

    always @(posedge aclk) begin
        #1;
        case (mready_mode)
            0: m_axis_tready = 1'b1;
            1: m_axis_tready = ($urandom_range(0, 3) != 0);
            default: m_axis_tready = 1'b0;
        endcase
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Packet-level reference: beats of a packet are taken two at a time, first
    // in the low half; a lone trailing beat gets an empty high half.
    task automatic model_accept(input beat_t b, input logic last);
        word_t w;
        logic [DW-1:0] hd;
        logic [KW-1:0] hk;
        logic [UW-1:0] hu;
        cur.push_back(b);
        if (cur.size() == 2 || last) begin
            hd = '0;
            hk = '0;
            hu = '0;
            if (cur.size() == 2) begin
                hd = cur[1].d;
                hk = cur[1].k;
                hu = cur[1].u;
            end
            w.data = {hd, cur[0].d};
            w.keep = {hk, cur[0].k};
            w.user = {hu, cur[0].u};
            w.last = last;
            w.cyc  = cyc;
            exp_q.push_back(w);
            cur.delete();
        end
    endtask

    // Monitor: a word presented with ready high is consumed at the next edge.
    always @(negedge aclk) begin
        if (reset) begin
            prev_v  = 1'b0;
            prev_hs = 1'b0;
        end else begin
            chk("pkt_count", 128'(pkt_count), 128'(model_count % (1 << CW)));
            if (m_axis_tvalid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got data %0h, expected no word", m_axis_tdata);
                end else begin
                    mon_w = exp_q[0];
                    chk("m_tdata", 128'(m_axis_tdata), 128'(mon_w.data));
                    chk("m_tkeep", 128'(m_axis_tkeep), 128'(mon_w.keep));
                    chk("m_tuser", 128'(m_axis_tuser), 128'(mon_w.user));
                    chk("m_tlast", 128'(m_axis_tlast), 128'(mon_w.last));
                    if (!prev_v || prev_hs) begin
                        chk("latency", 128'(cyc), 128'(mon_w.cyc + 1));
                    end
                    if (m_axis_tready) begin
                        void'(exp_q.pop_front());
                        if (mon_w.last) model_count++;
                    end
                end
            end
            prev_v  = m_axis_tvalid;
            prev_hs = m_axis_tvalid && m_axis_tready;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic do_reset(input int n);
        @(posedge aclk);
        #1;
        reset = 1'b1;
        s_axis_tvalid = 1'b0;
        cur.delete();
        exp_q.delete();
        model_count = 0;
        repeat (n) begin
            @(negedge aclk);
            chk("s_tready_in_reset", 128'(s_axis_tready), 128'(0));
        end
        @(posedge aclk);
        #1;
        reset = 1'b0;
        @(negedge aclk);
        chk("rst_m_tvalid", 128'(m_axis_tvalid), 128'(0));
        chk("rst_m_tlast", 128'(m_axis_tlast), 128'(0));
        chk("rst_pkt_count", 128'(pkt_count), 128'(0));
        chk("rst_s_tready", 128'(s_axis_tready), 128'(1));
    endtask

    task automatic idle();
        @(posedge aclk);
        #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic send_beat(input beat_t b, input logic last, input int gap, inout int stalls);
        int guard;
        @(posedge aclk);
        #1;
        if (gap > 0) begin
            s_axis_tvalid = 1'b0;
            repeat (gap) begin
                @(posedge aclk);
                #1;
            end
        end
        s_axis_tdata  = b.d;
        s_axis_tkeep  = b.k;
        s_axis_tuser  = b.u;
        s_axis_tlast  = last;
        s_axis_tvalid = 1'b1;
        guard = 0;
        forever begin
            @(negedge aclk);
            if (s_axis_tready) begin
                model_accept(b, last);
                break;
            end
            stalls++;
            guard++;
            if (guard > 2000) begin
                $display("FAIL s_accept_timeout: got no ready, expected ready within 2000 cycles");
                $fatal(1, "stuck");
            end
            @(posedge aclk);
            #1;
        end
    endtask

    function automatic beat_t rand_beat(input int keep_mode);
        beat_t b;
        b.d = {$urandom, $urandom};
        b.u = UW'($urandom);
        case (keep_mode)
            0: b.k = '1;
            default: b.k = ($urandom_range(0, 7) == 0) ? '0 : KW'($urandom);
        endcase
        return b;
    endfunction

    task automatic send_pkt(input int n, input int gap_max, input int keep_mode, inout int stalls);
        for (int i = 0; i < n; i++) begin
            send_beat(rand_beat(keep_mode), (i == n - 1), $urandom_range(0, gap_max), stalls);
        end
    endtask

    task automatic wait_drain(input string name);
        int guard;
        guard = 0;
        while ((exp_q.size() != 0 || m_axis_tvalid) && guard < 300) begin
            @(negedge aclk);
            guard++;
        end
        chk(name, 128'(exp_q.size()), 128'(0));
    endtask

    initial begin
        int st;
        beat_t b;

        do_reset(3);

        // 4-beat packet, full keep, always ready
        mready_mode = 0;
        st = 0;
        send_pkt(4, 0, 0, st);
        idle();
        chk("t1_stalls", 128'(st), 128'(0));
        wait_drain("t1_drain");
        chk("t1_count", 128'(pkt_count), 128'(1));

        // 3-beat packet: odd tail
        st = 0;
        send_pkt(3, 0, 0, st);
        idle();
        wait_drain("t2_drain");
        chk("t2_count", 128'(pkt_count), 128'(2));

        // single-beat packet, partial keep
        b = rand_beat(0);
        b.k = 8'h0F;
        st = 0;
        send_beat(b, 1'b1, 0, st);
        idle();
        wait_drain("t3_drain");
        chk("t3_count", 128'(pkt_count), 128'(3));

        // output stalled for 5 cycles with a word pending
        mready_mode = 2;
        @(posedge aclk);
        st = 0;
        send_beat(rand_beat(0), 1'b0, 0, st);
        send_beat(rand_beat(0), 1'b0, 0, st);
        b = rand_beat(0);
        @(posedge aclk);
        #1;
        s_axis_tdata  = b.d;
        s_axis_tkeep  = b.k;
        s_axis_tuser  = b.u;
        s_axis_tlast  = 1'b0;
        s_axis_tvalid = 1'b1;
        repeat (5) begin
            @(negedge aclk);
            chk("t4_s_tready_stall", 128'(s_axis_tready), 128'(0));
            chk("t4_m_tvalid_stall", 128'(m_axis_tvalid), 128'(1));
        end
        mready_mode = 0;
        send_beat(b, 1'b0, 0, st);
        send_beat(rand_beat(0), 1'b1, 0, st);
        idle();
        wait_drain("t4_drain");
        chk("t4_count", 128'(pkt_count), 128'(4));

        // back-to-back 2-beat and 1-beat packets
        st = 0;
        send_pkt(2, 0, 0, st);
        send_pkt(1, 0, 0, st);
        idle();
        chk("t5_stalls", 128'(st), 128'(0));
        wait_drain("t5_drain");
        chk("t5_count", 128'(pkt_count), 128'(6));

        // reset one cycle after the lo half is captured
        st = 0;
        send_beat(rand_beat(0), 1'b0, 0, st);
        idle();
        do_reset(2);
        st = 0;
        send_pkt(2, 0, 0, st);
        idle();
        wait_drain("t6_drain");
        chk("t6_count", 128'(pkt_count), 128'(1));

        // randomized traffic with backpressure; enough packets to wrap the counter
        mready_mode = 1;
        for (int p = 0; p < 300; p++) begin
            st = 0;
            send_pkt($urandom_range(1, 6), 2, 1, st);
        end
        idle();
        mready_mode = 0;
        wait_drain("rand_drain");
        chk("rand_count", 128'(pkt_count), 128'((301) % (1 << CW)));

        repeat (3) @(posedge aclk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
